// File: rtl/choreo8_pkg.sv
// Shared constants and pattern codes for the LED choreography blocks.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package choreo8_pkg;

  localparam int PAT_W = 3;

  typedef enum logic [PAT_W-1:0] {
    PAT_KNIGHT  = 3'd0,
    PAT_WALK    = 3'd1,
    PAT_EXPAND  = 3'd2,
    PAT_BLINK   = 3'd3,
    PAT_ALT     = 3'd4,
    PAT_MARQUEE = 3'd5,
    PAT_SPARKLE = 3'd6,
    PAT_OFF     = 3'd7
  } pat_e;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int LONG_CYCLES_DEF     = 64;
  localparam int CNT_W_DEF           = 8;

  // Next pattern in the cycle; 3-bit arithmetic wraps PAT_OFF back to PAT_KNIGHT.
  function automatic logic [PAT_W-1:0] pat_next(input logic [PAT_W-1:0] p);
    return p + 3'd1;
  endfunction

endpackage

// File: rtl/led_ctrl_input_if.sv
// Button inputs and pattern-generator control outputs of the LED control front-end.
// Latency: n/a (signal bundle only).
// Backpressure: none; buttons are raw levels and controls are plain registered levels.
interface led_ctrl_input_if;
  import choreo8_pkg::*;

  logic             btn_next;
  logic             btn_speed;
  logic             btn_pause;
  logic [PAT_W-1:0] pat_sel;
  logic             speed_sel;
  logic             pause;
  logic             pat_changed;

  // Driver side: pushes buttons, observes control state.
  modport master (
    output btn_next, btn_speed, btn_pause,
    input  pat_sel, speed_sel, pause, pat_changed
  );

  // Control block side: reads buttons, drives control state.
  modport slave (
    input  btn_next, btn_speed, btn_pause,
    output pat_sel, speed_sel, pause, pat_changed
  );

endinterface

// File: rtl/led_ctrl_input_btn_debounce.sv
// Synchronises and debounces one raw button, emitting one-cycle press/release pulses.
// Latency: level sampled at edge k flips the stable value at edge k+1+DEBOUNCE_CYCLES.
// Backpressure: none; shorter excursions are dropped silently.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_flip;

  // The stable value flips once the synchronised input has disagreed for the full window.
  assign w_flip    = (r_s2 != r_stable) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign o_level   = r_stable;
  assign o_press   = w_flip &  r_s2;
  assign o_release = w_flip & ~r_s2;

  // Two-flop synchroniser followed by the consecutive-disagreement counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_ctrl_input.sv
// Turns next/speed/pause buttons into registered pat_sel, speed_sel and pause controls.
// Latency: a press sampled at edge k updates the outputs at edge k+1+DEBOUNCE_CYCLES.
// Backpressure: none; every debounced press is acted on in the cycle it appears.
module led_ctrl_input
  import choreo8_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  led_ctrl_input_if.slave  bus
);

  logic w_next_level, w_next_press, w_next_release;
  logic w_speed_level, w_speed_press, w_speed_release;
  logic w_pause_level, w_pause_press, w_pause_release;
  logic w_unused_evt;

  logic [PAT_W-1:0] r_pat;
  logic             r_speed;
  logic             r_pause;
  logic             r_chg;
  logic [CNT_W-1:0] r_long_cnt;
  logic             r_long_fired;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_next (
    .clk(clk), .rst(rst), .i_btn(bus.btn_next),
    .o_level(w_next_level), .o_press(w_next_press), .o_release(w_next_release)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_speed (
    .clk(clk), .rst(rst), .i_btn(bus.btn_speed),
    .o_level(w_speed_level), .o_press(w_speed_press), .o_release(w_speed_release)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_pause (
    .clk(clk), .rst(rst), .i_btn(bus.btn_pause),
    .o_level(w_pause_level), .o_press(w_pause_press), .o_release(w_pause_release)
  );

  // Speed/pause levels and releases carry no action in this block.
  assign w_unused_evt = ^{w_speed_level, w_speed_release, w_pause_level, w_pause_release};

  // Control registers plus the long-press timer on "next"; a press re-arms the timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat        <= PAT_KNIGHT;
      r_speed      <= 1'b0;
      r_pause      <= 1'b0;
      r_chg        <= 1'b0;
      r_long_cnt   <= '0;
      r_long_fired <= 1'b0;
    end else begin
      r_chg <= 1'b0;
      if (w_speed_press) r_speed <= ~r_speed;
      if (w_pause_press) r_pause <= ~r_pause;

      if (w_next_press) begin
        r_pat        <= pat_next(r_pat);
        r_chg        <= 1'b1;
        r_long_cnt   <= '0;
        r_long_fired <= 1'b0;
      end else if (w_next_release) begin
        r_long_cnt <= '0;
      end else if (w_next_level && !r_long_fired) begin
        if (r_long_cnt == CNT_W'(LONG_CYCLES - 1)) begin
          // Fires once per hold, even when the pattern is already 0.
          r_pat        <= PAT_KNIGHT;
          r_chg        <= 1'b1;
          r_long_fired <= 1'b1;
        end else begin
          r_long_cnt <= r_long_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.pat_sel     = r_pat;
  assign bus.speed_sel   = r_speed;
  assign bus.pause       = r_pause;
  assign bus.pat_changed = r_chg;

endmodule
